tconv_chan_scheduler: RTL and testbench
=======================================

// Module: tconv_chan_scheduler
// PURPOSE
//  Layer-level sequencer for the single-channel transposed-conv engine (start_conv/end_conv core).
//  Runs the CO x CI channel loop: launches one engine pass per (co,ci) pair and generates IFM/weight read addresses.
//  Generates OFM write address/strobe; only the last-CI pass of each CO writes the OFM memory.
//  Sits between the layer DMA/top FSM and the engine, on the engine clock domain (clk1).
// PARAMETERS
//  IFM_SIZE     64   input feature map side (pixels, unpadded)
//  KERNEL_SIZE  5    kernel side
//  STRIDE       1    transposed-conv stride
//  PAD          2    padding
//  CI           3    input channels per layer
//  CO           8    output channels per layer
//  OFM_SIZE     (IFM_SIZE-1)*STRIDE-2*PAD+KERNEL_SIZE   output side (derived, do not override)
//  IFM_AW       $clog2(CI*IFM_SIZE*IFM_SIZE)            IFM address width
//  WGT_AW       $clog2(CO*CI*KERNEL_SIZE*KERNEL_SIZE)   weight address width
//  OFM_AW       $clog2(CO*OFM_SIZE*OFM_SIZE)            OFM address width
//  WDOG_CYCLES  1<<20  watchdog limit in cycles per pass (used only with TCONV_SCHED_WDOG_EN)
// PORTS
//  clk1           in   1       engine clock
//  rst            in   1       async reset, active high
//  start          in   1       layer start pulse; ignored unless IDLE
//  abort          in   1       sync abort; returns to IDLE next cycle, no done
//  busy           out  1       high from state LAUNCH through NEXT
//  done           out  1       one-cycle pulse after last pass
//  err            out  1       sticky error; cleared by rst or accepted start
//  conv_start     out  1       one-cycle pulse to engine start_conv
//  conv_ifm_read  in   1       engine consumed one IFM word
//  conv_wgt_read  in   1       engine consumed one weight word
//  conv_out_valid in   1       engine produced one OFM word
//  conv_end       in   1       engine pass complete (pulse)
//  ifm_addr       out  IFM_AW  IFM read address
//  wgt_addr       out  WGT_AW  weight read address
//  ofm_addr       out  OFM_AW  OFM write address
//  ofm_we         out  1       = conv_out_valid & last_ci & (state==RUN)
//  ci_idx         out  $clog2(CI)+1  current input channel
//  co_idx         out  $clog2(CO)+1  current output channel
//  last_ci        out  1       ci_idx==CI-1
// BEHAVIOUR
//  Reset: state IDLE; all outputs and counters 0 (err=0, done=0, conv_start=0).
//  FSM: IDLE -start-> LAUNCH -> RUN -conv_end-> NEXT -> LAUNCH | DONE -> IDLE.
//  Accepted start: ci=co=0, wgt_addr=0, ofm pixel count=0, err=0.
//  LAUNCH (1 cycle): conv_start=1; ifm_addr loaded with ci*IFM_SIZE^2; ofm_addr with co*OFM_SIZE^2; pass pix cnt=0.
//  RUN: ifm_addr+1 per conv_ifm_read; wgt_addr+1 per conv_wgt_read (never reloaded; linear over (co,ci));
//   pix cnt+1 per conv_out_valid; ofm_addr+1 only when ofm_we.
//  conv_end same cycle as out_valid/read strobes: strobes counted first, then transition to NEXT.
//  NEXT: if pix cnt != OFM_SIZE^2 set err (pass continues). ci<CI-1: ci+1; else ci=0, co+1.
//   If finished pair was (CO-1,CI-1) -> DONE else LAUNCH. DONE: done=1 one cycle -> IDLE.
//  Strobes from engine outside RUN are ignored (no counter change). start while busy ignored.
//  abort: any state -> IDLE next cycle; counters held, busy=0, done never pulses.
//  rst mid-layer: immediate return to reset values; engine must be reset alongside.
//  Latency: start->conv_start 1 cycle; conv_end->next conv_start 2 cycles; last conv_end->done 2 cycles.
// CONFIGURATION
//  TCONV_SCHED_WDOG_EN defined: cycle counter cleared in LAUNCH, increments in RUN; reaching
//   WDOG_CYCLES sets err and forces IDLE (no done).
//  Undefined: no counter; RUN waits for conv_end indefinitely; err only from pixel-count mismatch.
// TESTING  (IFM_SIZE=4,K=3,STRIDE=1,PAD=1 -> OFM_SIZE=4, CI=2,CO=2, engine BFM)
//  Full layer: start, BFM 16 out_valid/pass -> 4 conv_start pulses, done once, err=0, ofm_we 32x, ofm_addr 0..31.
//  Addressing: BFM 16 ifm_read/pass, 9 wgt_read/pass -> ifm_addr restarts 0,16,0,16; wgt_addr ends 36.
//  Count error: pass (0,1) gives 15 out_valid -> err=1 after that NEXT, layer still completes with done.
//  Simultaneous: out_valid with conv_end same cycle -> counted; no err for a 16-word pass.
//  Abort/restart: abort in RUN of pass 2 -> IDLE, busy=0, no done; new start -> full layer clean, err=0.
//  Watchdog (TCONV_SCHED_WDOG_EN, WDOG_CYCLES=100): BFM withholds conv_end -> err=1, IDLE at cycle 100.

Source files
------------

// File: rtl/tconv_chan_scheduler.sv
// ============================================================================
// tconv_chan_scheduler
// ----------------------------------------------------------------------------
// Layer-level sequencer for the single-channel transposed-conv engine.
//
// The engine handles one (output channel, input channel) pair per pass. This
// block walks all CO x CI pairs, one engine pass each, with CI as the inner
// loop. It supplies the IFM, weight and OFM addresses for every pass. Only the
// last-CI pass of each output channel writes the OFM memory. Earlier passes
// accumulate inside the engine.
//
// Build option:
//   TCONV_SCHED_WDOG_EN  When defined, a per-pass cycle watchdog is built in.
//                        If a RUN state lasts WDOG_CYCLES cycles, err is set
//                        and the sequencer returns to IDLE without done.
//                        When undefined, RUN waits for conv_end indefinitely.
//
// Ports:
//   clk1            engine clock
//   rst             asynchronous reset, active high
//   start           layer start pulse; accepted only in IDLE
//   abort           synchronous abort; returns to IDLE next cycle, no done
//   busy            high in LAUNCH, RUN and NEXT
//   done            one-cycle pulse after the last pass
//   err             sticky error flag; cleared by rst or by an accepted start
//   conv_start      one-cycle start pulse to the engine
//   conv_ifm_read   engine consumed one IFM word
//   conv_wgt_read   engine consumed one weight word
//   conv_out_valid  engine produced one OFM word
//   conv_end        engine pass complete (pulse)
//   ifm_addr        IFM read address
//   wgt_addr        weight read address; linear over the whole layer
//   ofm_addr        OFM write address
//   ofm_we          OFM write strobe (out_valid during a last-CI pass)
//   ci_idx, co_idx  current input / output channel
//   last_ci         current pass is the last input channel
// ============================================================================
module tconv_chan_scheduler #(
    parameter int IFM_SIZE    = 64,
    parameter int KERNEL_SIZE = 5,
    parameter int STRIDE      = 1,
    parameter int PAD         = 2,
    parameter int CI          = 3,
    parameter int CO          = 8,
    parameter int OFM_SIZE    = (IFM_SIZE - 1) * STRIDE - 2 * PAD + KERNEL_SIZE,
    parameter int IFM_AW      = $clog2(CI * IFM_SIZE * IFM_SIZE),
    parameter int WGT_AW      = $clog2(CO * CI * KERNEL_SIZE * KERNEL_SIZE),
    parameter int OFM_AW      = $clog2(CO * OFM_SIZE * OFM_SIZE)
`ifdef TCONV_SCHED_WDOG_EN
    ,
    parameter int WDOG_CYCLES = 1 << 20
`endif
) (
    input  logic                       clk1,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       conv_start,
    input  logic                       conv_ifm_read,
    input  logic                       conv_wgt_read,
    input  logic                       conv_out_valid,
    input  logic                       conv_end,
    output logic [IFM_AW-1:0]          ifm_addr,
    output logic [WGT_AW-1:0]          wgt_addr,
    output logic [OFM_AW-1:0]          ofm_addr,
    output logic                       ofm_we,
    output logic [$clog2(CI):0]        ci_idx,
    output logic [$clog2(CO):0]        co_idx,
    output logic                       last_ci
);

    localparam int CI_W  = $clog2(CI) + 1;
    localparam int CO_W  = $clog2(CO) + 1;
    // One spare bit so that an over-producing pass cannot wrap back to the
    // expected count. The counter also saturates.
    localparam int PIX_W = $clog2(OFM_SIZE * OFM_SIZE + 1) + 1;

    localparam logic [CI_W-1:0]   CI_LAST    = CI_W'(CI - 1);
    localparam logic [CO_W-1:0]   CO_LAST    = CO_W'(CO - 1);
    localparam logic [PIX_W-1:0]  PIX_TARGET = PIX_W'(OFM_SIZE * OFM_SIZE);
    localparam logic [PIX_W-1:0]  PIX_MAX    = '1;
    localparam logic [IFM_AW-1:0] IFM_PLANE  = IFM_AW'(IFM_SIZE * IFM_SIZE);
    localparam logic [OFM_AW-1:0] OFM_PLANE  = OFM_AW'(OFM_SIZE * OFM_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic [CI_W-1:0]   ci_reg;
    logic [CO_W-1:0]   co_reg;
    logic [IFM_AW-1:0] ifm_addr_reg;
    logic [WGT_AW-1:0] wgt_addr_reg;
    logic [OFM_AW-1:0] ofm_addr_reg;
    logic [PIX_W-1:0]  pix_cnt_reg;
    logic              err_reg;

    logic              last_pair;
    logic              ofm_we_int;
    logic              wdog_hit;

`ifdef TCONV_SCHED_WDOG_EN
    localparam int               WDOG_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt_reg;

    // The counter is 0 in the first RUN cycle. The hit therefore falls on the
    // WDOG_CYCLES-th RUN cycle.
    assign wdog_hit = (state_reg == ST_RUN) && (wdog_cnt_reg == WDOG_LAST);
`else
    assign wdog_hit = 1'b0;
`endif

    assign last_pair  = (ci_reg == CI_LAST) && (co_reg == CO_LAST);
    assign ofm_we_int = conv_out_valid && (ci_reg == CI_LAST) && (state_reg == ST_RUN);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_LAUNCH;
            ST_LAUNCH: state_next = ST_RUN;
            ST_RUN: begin
                // A pass that ends on the watchdog's last cycle counts as
                // completed.
                if (conv_end)      state_next = ST_NEXT;
                else if (wdog_hit) state_next = ST_IDLE;
            end
            ST_NEXT:   state_next = last_pair ? ST_DONE : ST_LAUNCH;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (abort) state_next = ST_IDLE;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // ------------------------------------------------------------------
    // Channel indices, address generators, pixel counter, error flag.
    // Abort freezes every counter, so the values at the abort stay readable.
    // ------------------------------------------------------------------
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            ci_reg       <= '0;
            co_reg       <= '0;
            ifm_addr_reg <= '0;
            wgt_addr_reg <= '0;
            ofm_addr_reg <= '0;
            pix_cnt_reg  <= '0;
            err_reg      <= 1'b0;
        end else if (!abort) begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        ci_reg       <= '0;
                        co_reg       <= '0;
                        wgt_addr_reg <= '0;
                        pix_cnt_reg  <= '0;
                        err_reg      <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    // Each channel has its own contiguous plane in the IFM
                    // and OFM memories.
                    ifm_addr_reg <= IFM_AW'(ci_reg) * IFM_PLANE;
                    ofm_addr_reg <= OFM_AW'(co_reg) * OFM_PLANE;
                    pix_cnt_reg  <= '0;
                end
                ST_RUN: begin
                    if (conv_ifm_read) ifm_addr_reg <= ifm_addr_reg + 1'b1;
                    if (conv_wgt_read) wgt_addr_reg <= wgt_addr_reg + 1'b1;
                    if (conv_out_valid && (pix_cnt_reg != PIX_MAX))
                        pix_cnt_reg <= pix_cnt_reg + 1'b1;
                    if (ofm_we_int) ofm_addr_reg <= ofm_addr_reg + 1'b1;
                    if (wdog_hit && !conv_end) err_reg <= 1'b1;
                end
                ST_NEXT: begin
                    // A short or long pass is flagged, but the layer still
                    // continues.
                    if (pix_cnt_reg != PIX_TARGET) err_reg <= 1'b1;
                    if (ci_reg == CI_LAST) begin
                        ci_reg <= '0;
                        co_reg <= co_reg + 1'b1;
                    end else begin
                        ci_reg <= ci_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TCONV_SCHED_WDOG_EN
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            wdog_cnt_reg <= '0;
        end else if (state_reg == ST_LAUNCH) begin
            wdog_cnt_reg <= '0;
        end else if ((state_reg == ST_RUN) && (wdog_cnt_reg != WDOG_LAST)) begin
            wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy       = (state_reg == ST_LAUNCH) || (state_reg == ST_RUN) ||
                        (state_reg == ST_NEXT);
    assign done       = (state_reg == ST_DONE);
    assign conv_start = (state_reg == ST_LAUNCH);
    assign err        = err_reg;
    assign ifm_addr   = ifm_addr_reg;
    assign wgt_addr   = wgt_addr_reg;
    assign ofm_addr   = ofm_addr_reg;
    assign ofm_we     = ofm_we_int;
    assign ci_idx     = ci_reg;
    assign co_idx     = co_reg;
    assign last_ci    = (ci_reg == CI_LAST);

endmodule

// File: tb/tb_tconv_chan_scheduler.sv
// ============================================================================
// tb_tconv_chan_scheduler
// Bench for tconv_chan_scheduler with a small layer: IFM 4x4, kernel 3,
// stride 1, pad 1 (OFM 4x4), CI=2, CO=2. A simple engine BFM drives the
// read and out_valid strobes. Expected OFM write addresses go into a queue.
// A negedge monitor pops and compares them whenever ofm_we fires.
// ============================================================================
module tb_tconv_chan_scheduler;

    localparam int IFM_SIZE = 4;
    localparam int KSIZE    = 3;
    localparam int STRIDE   = 1;
    localparam int PAD      = 1;
    localparam int CI       = 2;
    localparam int CO       = 2;
    localparam int IFM_AW   = 5;
    localparam int WGT_AW   = 6;
    localparam int OFM_AW   = 6;
    localparam int PIX      = 16;   // OFM_SIZE^2 and IFM_SIZE^2
    localparam int WPASS    = 9;    // weight words per pass

    logic              clk1;
    logic              rst;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              err;
    logic              conv_start;
    logic              conv_ifm_read;
    logic              conv_wgt_read;
    logic              conv_out_valid;
    logic              conv_end;
    logic [IFM_AW-1:0] ifm_addr;
    logic [WGT_AW-1:0] wgt_addr;
    logic [OFM_AW-1:0] ofm_addr;
    logic              ofm_we;
    logic [1:0]        ci_idx;
    logic [1:0]        co_idx;
    logic              last_ci;

    tconv_chan_scheduler #(
        .IFM_SIZE    (IFM_SIZE),
        .KERNEL_SIZE (KSIZE),
        .STRIDE      (STRIDE),
        .PAD         (PAD),
        .CI          (CI),
        .CO          (CO)
`ifdef TCONV_SCHED_WDOG_EN
        ,
        .WDOG_CYCLES (100)
`endif
    ) dut (
        .clk1           (clk1),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .conv_start     (conv_start),
        .conv_ifm_read  (conv_ifm_read),
        .conv_wgt_read  (conv_wgt_read),
        .conv_out_valid (conv_out_valid),
        .conv_end       (conv_end),
        .ifm_addr       (ifm_addr),
        .wgt_addr       (wgt_addr),
        .ofm_addr       (ofm_addr),
        .ofm_we         (ofm_we),
        .ci_idx         (ci_idx),
        .co_idx         (co_idx),
        .last_ci        (last_ci)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;
    int done_cnt  = 0;
    int we_cnt    = 0;
    int exp_wgt   = 0;
    int exp_addr;
    int exp_q[$];

    // Monitor: counts pulses and checks OFM writes against the scoreboard.
    always @(negedge clk1) begin
        if (!rst) begin
            if (conv_start) start_cnt++;
            if (done) done_cnt++;
            if (ofm_we) begin
                we_cnt++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ofm_write_unexpected: ofm_addr=%0d, expected no write", ofm_addr);
                end else begin
                    exp_addr = exp_q.pop_front();
                    if (ofm_addr !== OFM_AW'(exp_addr)) begin
                        n_fail++;
                        $display("FAIL ofm_write_addr: got %0d, expected %0d", ofm_addr, exp_addr);
                    end else begin
                        $display("[TB] ofm write addr=%0d ok", ofm_addr);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic clear_strobes();
        conv_ifm_read  = 1'b0;
        conv_wgt_read  = 1'b0;
        conv_out_valid = 1'b0;
        conv_end       = 1'b0;
    endtask

    // Entered during the LAUNCH cycle (#1 after the edge). Returns in the
    // NEXT cycle (#1 after the edge that sampled conv_end).
    task automatic run_pass(input int co, input int ci, input int n_out,
                            input int n_ifm, input int n_wgt, input bit simul);
        int n;
        n = n_out;
        if (n_ifm > n) n = n_ifm;
        if (n_wgt > n) n = n_wgt;
        tick();   // RUN
        n_tests++;
        if (ifm_addr !== IFM_AW'(ci * PIX) || ofm_addr !== OFM_AW'(co * PIX) ||
            wgt_addr !== WGT_AW'(exp_wgt)) begin
            n_fail++;
            $display("FAIL pass_base(%0d,%0d): ifm=%0d ofm=%0d wgt=%0d, expected ifm=%0d ofm=%0d wgt=%0d",
                     co, ci, ifm_addr, ofm_addr, wgt_addr, ci * PIX, co * PIX, exp_wgt);
        end
        n_tests++;
        if (ci_idx !== 2'(ci) || co_idx !== 2'(co) || last_ci !== (ci == CI - 1) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_idx(%0d,%0d): ci=%0d co=%0d last_ci=%0b busy=%0b", co, ci,
                     ci_idx, co_idx, last_ci, busy);
        end
        for (int i = 0; i < n; i++) begin
            conv_out_valid = (i < n_out);
            conv_ifm_read  = (i < n_ifm);
            conv_wgt_read  = (i < n_wgt);
            conv_end       = simul && (i == n - 1);
            if ((i < n_out) && (ci == CI - 1)) exp_q.push_back(co * PIX + i);
            tick();
        end
        clear_strobes();
        if (!simul) begin
            conv_end = 1'b1;
            tick();
            conv_end = 1'b0;
        end
        exp_wgt += n_wgt;
        n_tests++;
        if (ifm_addr !== IFM_AW'(ci * PIX + n_ifm) || wgt_addr !== WGT_AW'(exp_wgt) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_end(%0d,%0d): ifm=%0d wgt=%0d busy=%0b, expected ifm=%0d wgt=%0d busy=1",
                     co, ci, ifm_addr, wgt_addr, busy, (ci * PIX + n_ifm) % 32, exp_wgt);
        end
        $display("[TB] pass (co=%0d,ci=%0d) out=%0d simul=%0b", co, ci, n_out, simul);
    endtask

    // Runs a whole layer. The pass (bad_co,bad_ci) delivers one word short.
    task automatic run_layer(input string name, input int bad_co, input int bad_ci, input bit simul);
        int s0, d0, w0, nw, nout;
        bit exp_err;
        s0 = start_cnt; d0 = done_cnt; w0 = we_cnt; nw = 0;
        exp_err = 1'b0;
        exp_wgt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (conv_start !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_start_latency: conv_start=%0b busy=%0b err=%0b, expected 1 1 0",
                     name, conv_start, busy, err);
        end
        for (int co = 0; co < CO; co++) begin
            for (int ci = 0; ci < CI; ci++) begin
                nout = ((co == bad_co) && (ci == bad_ci)) ? PIX - 1 : PIX;
                if (ci == CI - 1) nw += nout;
                run_pass(co, ci, nout, PIX, WPASS, simul);
                if (nout != PIX) exp_err = 1'b1;
                tick();
                n_tests++;
                if ((co == CO - 1) && (ci == CI - 1)) begin
                    if (done !== 1'b1 || err !== exp_err || conv_start !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s_done_latency: done=%0b err=%0b conv_start=%0b, expected 1 %0b 0",
                                 name, done, err, conv_start, exp_err);
                    end
                end else begin
                    if (conv_start !== 1'b1 || err !== exp_err || done !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s_relaunch: conv_start=%0b err=%0b done=%0b, expected 1 %0b 0",
                                 name, conv_start, err, done, exp_err);
                    end
                end
            end
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: done=%0b busy=%0b, expected 0 0", name, done, busy);
        end
        n_tests++;
        if (start_cnt - s0 != CO * CI || done_cnt - d0 != 1 || we_cnt - w0 != nw ||
            exp_q.size() != 0 || wgt_addr !== WGT_AW'(CO * CI * WPASS) || err !== exp_err) begin
            n_fail++;
            $display("FAIL %s_totals: starts=%0d dones=%0d writes=%0d pending=%0d wgt=%0d err=%0b, expected %0d 1 %0d 0 %0d %0b",
                     name, start_cnt - s0, done_cnt - d0, we_cnt - w0, exp_q.size(), wgt_addr, err,
                     CO * CI, nw, CO * CI * WPASS, exp_err);
        end
        $display("[TB] layer %s: starts=%0d dones=%0d writes=%0d err=%0b", name,
                 start_cnt - s0, done_cnt - d0, we_cnt - w0, err);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        clear_strobes();
        tick(); tick();
        n_tests++;
        if ({busy, done, err, conv_start, ofm_we, last_ci} !== 6'b0 ||
            ifm_addr !== '0 || wgt_addr !== '0 || ofm_addr !== '0 ||
            ci_idx !== 2'b0 || co_idx !== 2'b0) begin
            n_fail++;
            $display("FAIL reset_values: busy=%0b done=%0b err=%0b cs=%0b we=%0b last=%0b ifm=%0d wgt=%0d ofm=%0d ci=%0d co=%0d, expected all 0",
                     busy, done, err, conv_start, ofm_we, last_ci, ifm_addr, wgt_addr, ofm_addr, ci_idx, co_idx);
        end
        rst = 1'b0;
        tick();
        $display("[TB] reset checked");
    endtask

    task automatic test_full_layer();
        run_layer("full", -1, -1, 1'b0);
    endtask

    task automatic test_count_error();
        run_layer("cnterr", 0, 1, 1'b0);
    endtask

    task automatic test_simultaneous();
        run_layer("simul", -1, -1, 1'b1);
    endtask

    task automatic test_abort_restart();
        int d0;
        logic [IFM_AW-1:0] ifm_s;
        logic [WGT_AW-1:0] wgt_s;
        logic [OFM_AW-1:0] ofm_s;
        d0 = done_cnt;
        exp_wgt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_pass(0, 0, PIX, PIX, WPASS, 1'b0);
        tick();    // LAUNCH of pass (0,1)
        tick();    // RUN
        for (int i = 0; i < 3; i++) begin
            conv_out_valid = 1'b1;
            start = (i == 0);   // start while busy must be ignored
            exp_q.push_back(i);
            tick();
            start = 1'b0;
            if (i == 0) begin
                n_tests++;
                if (busy !== 1'b1 || conv_start !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_while_busy: busy=%0b conv_start=%0b, expected 1 0", busy, conv_start);
                end
            end
        end
        clear_strobes();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || conv_start !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%0b conv_start=%0b done=%0b, expected 0 0 0", busy, conv_start, done);
        end
        // Engine strobes while idle must not move any counter.
        ifm_s = ifm_addr; wgt_s = wgt_addr; ofm_s = ofm_addr;
        conv_ifm_read = 1'b1; conv_wgt_read = 1'b1; conv_out_valid = 1'b1; conv_end = 1'b1;
        tick(); tick();
        clear_strobes();
        tick(); tick();
        n_tests++;
        if (ifm_addr !== ifm_s || wgt_addr !== wgt_s || ofm_addr !== ofm_s ||
            done_cnt != d0 || exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_strobes: ifm=%0d/%0d wgt=%0d/%0d ofm=%0d/%0d dones=%0d pending=%0d busy=%0b",
                     ifm_addr, ifm_s, wgt_addr, wgt_s, ofm_addr, ofm_s, done_cnt - d0, exp_q.size(), busy);
        end
        $display("[TB] abort checked");
        run_layer("restart", -1, -1, 1'b0);
    endtask

    task automatic test_reset_mid_layer();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();    // RUN
        conv_ifm_read = 1'b1; conv_wgt_read = 1'b1;
        tick(); tick(); tick();
        clear_strobes();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || ifm_addr !== '0 || wgt_addr !== '0 || conv_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_layer: busy=%0b ifm=%0d wgt=%0d cs=%0b, expected all 0",
                     busy, ifm_addr, wgt_addr, conv_start);
        end
        tick();
        rst = 1'b0;
        tick();
        $display("[TB] reset mid-layer checked");
    endtask

`ifdef TCONV_SCHED_WDOG_EN
    task automatic test_watchdog();
        int cyc, d0;
        d0 = done_cnt;
        cyc = 0;
        start = 1'b1;
        tick();    // LAUNCH
        start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (busy !== 1'b1) break;
            cyc++;
        end
        n_tests++;
        if (cyc != 100 || err !== 1'b1 || busy !== 1'b0 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL watchdog: run_cycles=%0d err=%0b busy=%0b dones=%0d, expected 100 1 0 0",
                     cyc, err, busy, done_cnt - d0);
        end
        $display("[TB] watchdog run_cycles=%0d err=%0b", cyc, err);
    endtask
`endif

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        clear_strobes();
        test_reset();
        test_full_layer();
        test_count_error();
        test_simultaneous();
        test_abort_restart();
        test_reset_mid_layer();
`ifdef TCONV_SCHED_WDOG_EN
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
